// File: rtl/score_disp_sched.sv
// Purpose: two-source (player/dealer) scheduler for a 2-digit 7-seg path; binary->BCD by repeated subtraction.
// Latency: a score load sampled in IDLE at edge 0 shows its digits at edge 2+floor(v/10), at most edge 5.
// Backpressure: none; loads always land in their score register, and BUSY only reports an active conversion.
// Optional bust blink (shown value > 21) is enabled by defining SCORE_BLINK_EN.
module score_disp_sched #(
  parameter int HOLD_TICKS  = 8,
  parameter int BLINK_TICKS = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TICK,
  input  logic       P_LD,
  input  logic [4:0] P_SCORE,
  input  logic       D_LD,
  input  logic [4:0] D_SCORE,
  input  logic       CLR,
  output logic [1:0] DIGIT_H,
  output logic [3:0] DIGIT_L,
  output logic       OFF,
  output logic       SRC,
  output logic       BUSY
);

  // Reject parameter values that would make the counters meaningless.
  if (HOLD_TICKS < 1 || BLINK_TICKS < 1) begin : g_param_chk
    $error("score_disp_sched: HOLD_TICKS and BLINK_TICKS must both be >= 1");
  end

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CONV = 2'd2,
    SHOW = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched scores and their valid flags.
  logic [4:0] p_reg;
  logic [4:0] d_reg;
  logic       p_vld;
  logic       d_vld;

  // Conversion datapath: remainder and tens count during repeated subtraction.
  logic [4:0] rem;
  logic [1:0] tens;

  logic [HOLD_W-1:0] hold_cnt;

  // Views that include a load strobe arriving in the current cycle, so a
  // load sampled in IDLE starts the conversion at the very next edge and a
  // same-cycle load is never missed by the source selection.
  logic       p_vld_eff;
  logic       d_vld_eff;
  logic [4:0] p_val_eff;
  logic [4:0] d_val_eff;
  logic [4:0] sel_val;
  logic       reload_shown;
  logic       other_vld;
  logic       hold_done;
  logic       conv_done;

  assign p_vld_eff    = p_vld | P_LD;
  assign d_vld_eff    = d_vld | D_LD;
  assign p_val_eff    = P_LD ? P_SCORE : p_reg;
  assign d_val_eff    = D_LD ? D_SCORE : d_reg;
  assign sel_val      = SRC ? d_val_eff : p_val_eff;
  assign reload_shown = SRC ? D_LD : P_LD;
  assign other_vld    = SRC ? p_vld_eff : d_vld_eff;
  assign hold_done    = TICK && (hold_cnt == HOLD_LAST);
  assign conv_done    = (rem < 5'd10);

`ifdef SCORE_BLINK_EN
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               bust;

  // The displayed value exceeds 21 exactly when tens is 3, or tens is 2 with units above 1.
  assign bust = (DIGIT_H == 2'd3) || ((DIGIT_H == 2'd2) && (DIGIT_L > 4'd1));
`endif

  // State register; reset and CLR both force IDLE.
  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A reload of the shown source wins over hold expiry and
  // restarts a conversion in flight so stale digits are never presented.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (p_vld_eff || d_vld_eff) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = CONV;
      end
      CONV: begin
        if (reload_shown) begin
          state_nxt = LOAD;
        end else if (conv_done) begin
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (reload_shown) begin
          state_nxt = LOAD;
        end else if (hold_done && other_vld) begin
          state_nxt = LOAD;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Score registers: a load strobe always captures, CLR outranks it.
  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      p_reg <= 5'd0;
      p_vld <= 1'b0;
      d_reg <= 5'd0;
      d_vld <= 1'b0;
    end else begin
      if (P_LD) begin
        p_reg <= P_SCORE;
        p_vld <= 1'b1;
      end
      if (D_LD) begin
        d_reg <= D_SCORE;
        d_vld <= 1'b1;
      end
    end
  end

  // Conversion datapath and registered display outputs; digits and OFF only
  // change when a conversion completes, so LOAD/CONV keep the old picture.
  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      rem     <= 5'd0;
      tens    <= 2'd0;
      DIGIT_H <= 2'd0;
      DIGIT_L <= 4'd0;
      OFF     <= 1'b1;
      SRC     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          OFF <= 1'b1;
          if (p_vld_eff) begin
            SRC <= 1'b0;
          end else if (d_vld_eff) begin
            SRC <= 1'b1;
          end
        end
        LOAD: begin
          rem  <= sel_val;
          tens <= 2'd0;
          BUSY <= 1'b1;
        end
        CONV: begin
          BUSY <= 1'b1;
          if (!reload_shown) begin
            if (conv_done) begin
              DIGIT_L <= rem[3:0];
              DIGIT_H <= tens;
              OFF     <= 1'b0;
              BUSY    <= 1'b0;
            end else begin
              rem  <= rem - 5'd10;
              tens <= tens + 2'd1;
            end
          end
        end
        SHOW: begin
          if (!reload_shown && hold_done && other_vld) begin
            SRC <= ~SRC;
          end
`ifdef SCORE_BLINK_EN
          if (!reload_shown && TICK && bust && (blink_cnt == BLINK_LAST)) begin
            OFF <= ~OFF;
          end
`endif
        end
        default: begin
          BUSY <= 1'b0;
        end
      endcase
    end
  end

  // Hold (and blink) timebase: counts TICKs only in SHOW, cleared as each new
  // picture is presented, held during LOAD/CONV.
  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      hold_cnt <= '0;
    end else if (state == CONV && !reload_shown && conv_done) begin
      hold_cnt <= '0;
    end else if (state == SHOW && !reload_shown && TICK) begin
      if (hold_done) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

`ifdef SCORE_BLINK_EN
  // Blink half-period counter; only advances while a bust score is shown.
  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      blink_cnt <= '0;
    end else if (state == CONV && !reload_shown && conv_done) begin
      blink_cnt <= '0;
    end else if (state == SHOW && !reload_shown && TICK && bust) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_score_disp_sched.sv
// Purpose: directed self-checking bench for score_disp_sched with hand-computed expectations.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is a fixed sequence of edges.
module tb_score_disp_sched;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       p_ld;
  logic [4:0] p_score;
  logic       d_ld;
  logic [4:0] d_score;
  logic       clr;
  logic [1:0] digit_h;
  logic [3:0] digit_l;
  logic       off;
  logic       src;
  logic       busy;

  int checks;
  int failures;

`ifdef SCORE_BLINK_EN
  localparam int BLINK_ON = 1;
`else
  localparam int BLINK_ON = 0;
`endif

  score_disp_sched #(
    .HOLD_TICKS (8),
    .BLINK_TICKS(4)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .TICK   (tick),
    .P_LD   (p_ld),
    .P_SCORE(p_score),
    .D_LD   (d_ld),
    .D_SCORE(d_score),
    .CLR    (clr),
    .DIGIT_H(digit_h),
    .DIGIT_L(digit_l),
    .OFF    (off),
    .SRC    (src),
    .BUSY   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // n one-cycle TICK pulses, each followed by a quiet cycle.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic chk_disp(input string tag, input int h, input int l, input int o, input int s);
    chk({tag, "_h"},   int'(digit_h), h);
    chk({tag, "_l"},   int'(digit_l), l);
    chk({tag, "_off"}, int'(off),     o);
    chk({tag, "_src"}, int'(src),     s);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic load_p(input int v);
    p_ld    = 1'b1;
    p_score = 5'(v);
    step();
    p_ld    = 1'b0;
  endtask

  initial begin
    int busy_seen;
    int src_seen;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    tick     = 1'b0;
    p_ld     = 1'b0;
    p_score  = 5'd0;
    d_ld     = 1'b0;
    d_score  = 5'd0;
    clr      = 1'b0;

    // Reset values.
    steps(2);
    chk_disp("rst", 0, 0, 1, 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    steps(2);
    chk("idle_off", int'(off), 1);

    // Player 21: BUSY on edges 1..3, digits at edge 4.
    load_p(21);
    chk("p21_e0_busy", int'(busy), 0);
    step();
    chk("p21_e1_busy", int'(busy), 1);
    chk("p21_e1_off", int'(off), 1);
    step();
    chk("p21_e2_busy", int'(busy), 1);
    step();
    chk("p21_e3_busy", int'(busy), 1);
    step();
    chk_disp("p21_e4", 2, 1, 0, 0);
    chk("p21_e4_busy", int'(busy), 0);

    // Both loaded together: player first, alternate every 8 TICKs.
    do_clr();
    p_ld = 1'b1; p_score = 5'd7;
    d_ld = 1'b1; d_score = 5'd19;
    step();
    p_ld = 1'b0; d_ld = 1'b0;
    steps(2);
    chk_disp("pd_first", 0, 7, 0, 0);
    tick_n(7);
    chk("pd_7t_src", int'(src), 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk_disp("pd_swap", 0, 7, 0, 1);
    steps(2);
    chk("pd_swap_e2_l", int'(digit_l), 7);
    chk("pd_swap_e2_busy", int'(busy), 1);
    step();
    chk_disp("pd_dealer", 1, 9, 0, 1);
    tick_n(7);
    chk("pd_back_7t_src", int'(src), 1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("pd_back_src", int'(src), 0);
    steps(3);
    chk_disp("pd_back", 0, 7, 0, 0);

    // Bust 25: blinks only when the macro is defined.
    do_clr();
    load_p(25);
    steps(4);
    chk_disp("b25", 2, 5, 0, 0);
    tick_n(3);
    chk("b25_3t_off", int'(off), 0);
    tick_n(1);
    chk("b25_4t_off", int'(off), BLINK_ON);
    tick_n(3);
    chk("b25_7t_off", int'(off), BLINK_ON);
    tick_n(1);
    chk("b25_8t_off", int'(off), 0);
    chk("b25_8t_busy", int'(busy), 0);
    chk("b25_8t_src", int'(src), 0);

    // Reload of shown player; dealer load must not steal the display.
    do_clr();
    load_p(5);
    steps(2);
    chk_disp("p5", 0, 5, 0, 0);
    d_ld = 1'b1; d_score = 5'd12;
    step();
    d_ld = 1'b0;
    tick_n(3);
    chk("p5_dld_src", int'(src), 0);
    chk("p5_dld_l", int'(digit_l), 5);
    load_p(30);
    steps(4);
    chk("p30_e4_busy", int'(busy), 1);
    step();
    chk_disp("p30", 3, 0, 0, 0);

    // CLR together with D_LD during a conversion.
    load_p(31);
    step();
    chk("conv_busy", int'(busy), 1);
    clr = 1'b1; d_ld = 1'b1; d_score = 5'd9;
    step();
    clr = 1'b0; d_ld = 1'b0;
    chk_disp("clr_conv", 0, 0, 1, 0);
    chk("clr_conv_busy", int'(busy), 0);
    steps(4);
    chk("clr_dvld_busy", int'(busy), 0);
    chk("clr_dvld_off", int'(off), 1);

    // Reset during SHOW.
    load_p(14);
    steps(3);
    chk_disp("p14", 1, 4, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_disp("rst_show", 0, 0, 1, 0);
    chk("rst_show_busy", int'(busy), 0);
    steps(4);
    chk("rst_show_idle_off", int'(off), 1);

    // Only player valid over 20 TICKs: never re-enters LOAD.
    load_p(9);
    steps(2);
    chk_disp("p9", 0, 9, 0, 0);
    busy_seen = 0;
    src_seen  = 0;
    for (int i = 0; i < 20; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (busy) busy_seen = 1;
      if (src) src_seen = 1;
      step();
      if (busy) busy_seen = 1;
      if (src) src_seen = 1;
    end
    chk("solo_busy_seen", busy_seen, 0);
    chk("solo_src_seen", src_seen, 0);
    chk_disp("solo_end", 0, 9, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
